// File: rtl/fetch_decode_if.sv
// Fetch/decode bus bundle: PC address, imem port, ALU flag, redirects, issue.
// Latency: none (wires only).
// Backpressure: none; the PC advances every cycle and follows jump/branch.
interface fetch_decode_if;
    logic [7:0]  address;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        alu_zero;
    logic        jump;
    logic [7:0]  jump_adr;
    logic        branch;
    logic [7:0]  branch_adr;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        halted;

    // Environment side: PC, instruction memory and execute stage.
    modport master (
        output address, imem_rdata, alu_zero,
        input  imem_addr, jump, jump_adr, branch, branch_adr,
        input  instr, instr_pc, instr_valid, halted
    );

    // Fetch/decode block side.
    modport slave (
        input  address, imem_rdata, alu_zero,
        output imem_addr, jump, jump_adr, branch, branch_adr,
        output instr, instr_pc, instr_valid, halted
    );
endinterface

// File: rtl/fetch_decode.sv
// Fetch/decode: reads imem at the PC, decodes JMP/BZ/BNZ/HALT, issues the rest.
// Latency: address in cycle t is decoded/issued in cycle t+2.
// Backpressure: none; taken transfers squash the two wrong-path words in flight.
module fetch_decode (
    input  logic           clk,
    input  logic           reset,
    fetch_decode_if.slave  bus
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [3:0] OP_BNZ  = 4'hC;
    localparam logic [3:0] OP_BZ   = 4'hD;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Fetch stage: address of the word currently on imem_rdata.
    logic [7:0]  addr_d1_q, addr_d1_d;
    logic        vld_d1_q,  vld_d1_d;

    // Instruction register stage.
    logic [15:0] ir_q,      ir_d;
    logic [7:0]  ir_pc_q,   ir_pc_d;
    logic        ir_vld_q,  ir_vld_d;

    // Wrong-path words still to be discarded after the current IR load.
    logic [1:0]  squash_cnt_q, squash_cnt_d;

    state_t      state_q, state_d;
    logic [7:0]  halt_pc_q, halt_pc_d;

    // Decode results.
    logic        jump_c;
    logic [7:0]  jump_adr_c;
    logic        branch_c;
    logic [7:0]  branch_adr_c;
    logic        issue_c;
    logic        taken_c;
    logic [1:0]  squash_eff;

    logic [3:0]  opcode;
    logic [7:0]  target;

    assign opcode = ir_q[15:12];
    assign target = ir_q[7:0];

    // Decode the IR and choose the next control state.
    always_comb begin
        jump_c       = 1'b0;
        jump_adr_c   = 8'h00;
        branch_c     = 1'b0;
        branch_adr_c = 8'h00;
        issue_c      = 1'b0;
        state_d      = state_q;
        halt_pc_d    = halt_pc_q;
        case (state_q)
            ST_RUN: begin
                if (ir_vld_q) begin
                    case (opcode)
                        OP_JMP: begin
                            jump_c     = 1'b1;
                            jump_adr_c = target;
                        end
                        OP_BZ: begin
                            if (bus.alu_zero) begin
                                branch_c     = 1'b1;
                                branch_adr_c = target;
                            end
                        end
                        OP_BNZ: begin
                            if (!bus.alu_zero) begin
                                branch_c     = 1'b1;
                                branch_adr_c = target;
                            end
                        end
                        OP_HALT: begin
                            state_d   = ST_HALT;
                            halt_pc_d = ir_pc_q;
                        end
                        default: begin
                            issue_c = 1'b1;
                        end
                    endcase
                end
            end
            ST_HALT: begin
                // Keep the PC pinned on the HALT instruction until reset.
                jump_c     = 1'b1;
                jump_adr_c = halt_pc_q;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // A redirect only counts as taken in RUN; the HALT spin needs no squash.
    assign taken_c = (state_q == ST_RUN) && (jump_c || branch_c);

    // Fetch/IR next state. A taken transfer kills the load on this very edge
    // (PC+1) and the next one (PC+2), so the effective count at this edge is
    // 2 and what is left over after the load is stored.
    always_comb begin
        addr_d1_d    = bus.address;
        vld_d1_d     = 1'b1;
        squash_eff   = taken_c ? 2'd2 : squash_cnt_q;
        ir_d         = bus.imem_rdata;
        ir_pc_d      = addr_d1_q;
        ir_vld_d     = vld_d1_q && (squash_eff == 2'd0);
        squash_cnt_d = (squash_eff == 2'd0) ? 2'd0 : squash_eff - 2'd1;
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RUN;
            halt_pc_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            halt_pc_q <= halt_pc_d;
        end
    end

    // Fetch pipeline, IR and squash counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_d1_q    <= 8'h00;
            vld_d1_q     <= 1'b0;
            ir_q         <= 16'h0000;
            ir_pc_q      <= 8'h00;
            ir_vld_q     <= 1'b0;
            squash_cnt_q <= 2'd0;
        end else begin
            addr_d1_q    <= addr_d1_d;
            vld_d1_q     <= vld_d1_d;
            ir_q         <= ir_d;
            ir_pc_q      <= ir_pc_d;
            ir_vld_q     <= ir_vld_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign bus.imem_addr   = bus.address;
    assign bus.jump        = jump_c;
    assign bus.jump_adr    = jump_adr_c;
    assign bus.branch      = branch_c;
    assign bus.branch_adr  = branch_adr_c;
    assign bus.instr       = ir_q;
    assign bus.instr_pc    = ir_pc_q;
    assign bus.instr_valid = issue_c;
    assign bus.halted      = (state_q == ST_HALT);

endmodule
